// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end. It issues PC addresses to a 1-cycle instruction
// memory and buffers the returned words in a 2-entry queue that feeds decode.
module instr_fetch_unit #(
  parameter logic [15:0] HALT_OP = 16'hFFFF
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  pc_addr,
  output logic        pc_en,
  output logic [7:0]  imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        flush,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [15:0] dec_instr,
  output logic [7:0]  dec_pc,
  output logic        halted,
  output logic [1:0]  dbg_state,
  output logic [1:0]  dbg_count,
  output logic        dbg_inflight
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [15:0] q_instr [0:1];
  logic [7:0]  q_pc    [0:1];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;
  logic [1:0]  count_nxt;
  logic        inflight;
  logic [7:0]  tag;

  logic        push;
  logic        pop;
  logic        issue;
  logic        halt_ret;
  logic        push_halt;
  logic [2:0]  occupancy;

  // Decode handshake: the head entry transfers on any rising edge where
  // dec_valid and dec_ready are both high; dec_valid never depends on dec_ready.
  assign dec_valid = (count != 2'd0) && !flush;
  assign pop       = dec_valid && dec_ready;
  assign dec_instr = q_instr[rd_ptr];
  assign dec_pc    = q_pc[rd_ptr];

  // The memory word returning this cycle belongs to the address captured in tag.
  assign push      = inflight && !flush;
  assign halt_ret  = inflight && (imem_rdata == HALT_OP);
  assign push_halt = push && (imem_rdata == HALT_OP);

  // Slots still claimed after this cycle, counting the word already on its way.
  assign occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};

  assign issue     = (state == RUN) && !flush && (occupancy < 3'd2) && !halt_ret;
  assign pc_en     = issue;
  assign imem_addr = pc_addr;
  assign halted    = (state == HALTED);

  assign dbg_state    = state;
  assign dbg_count    = count;
  assign dbg_inflight = inflight;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = RUN;
      RUN:     if (push_halt) state_nxt = HALTED;
      HALTED:  if (flush) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 2'd1;
      2'b01:   count_nxt = count - 2'd1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Flush wins over every other event: the queue empties and the returning word is dropped.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      count    <= 2'd0;
      inflight <= 1'b0;
      tag      <= 8'h00;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
    end else if (flush) begin
      count    <= 2'd0;
      inflight <= 1'b0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
    end else begin
      count    <= count_nxt;
      inflight <= issue;
      if (issue) tag <= pc_addr;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop) rd_ptr <= ~rd_ptr;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      q_instr[0] <= 16'h0000;
      q_instr[1] <= 16'h0000;
      q_pc[0]    <= 8'h00;
      q_pc[1]    <= 8'h00;
    end else if (push) begin
      q_instr[wr_ptr] <= imem_rdata;
      q_pc[wr_ptr]    <= tag;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: PC and 1-cycle memory models, a scripted
// sequence of streaming, stall, flush, halt, reset and wrap scenarios.
module tb_instr_fetch_unit;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [7:0]  pc_addr;
  logic        pc_en;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        flush;
  logic        dec_valid;
  logic        dec_ready;
  logic [15:0] dec_instr;
  logic [7:0]  dec_pc;
  logic        halted;
  logic [1:0]  dbg_state;
  logic [1:0]  dbg_count;
  logic        dbg_inflight;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic [23:0] exp_q[$];
  logic [7:0]  redirect_pc;
  logic        halt_en;
  logic [7:0]  halt_addr;

  int R, F, G, H, R2, W;

  instr_fetch_unit #(.HALT_OP(16'hFFFF)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .pc_addr      (pc_addr),
    .pc_en        (pc_en),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .flush        (flush),
    .dec_valid    (dec_valid),
    .dec_ready    (dec_ready),
    .dec_instr    (dec_instr),
    .dec_pc       (dec_pc),
    .halted       (halted),
    .dbg_state    (dbg_state),
    .dbg_count    (dbg_count),
    .dbg_inflight (dbg_inflight)
  );

  // Clock and cycle index (cyc == k during the cycle after rising edge k)
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // PC block: resets to 0, redirects on flush, advances on pc_en
  always @(posedge CLK or posedge RESET) begin
    if (RESET) pc_addr <= 8'h00;
    else if (flush) pc_addr <= redirect_pc;
    else if (pc_en) pc_addr <= pc_addr + 8'd1;
  end

  // Instruction memory: word = 16'h1000 + addr, optional halt opcode at halt_addr
  always @(posedge CLK) begin
    if (halt_en && (imem_addr == halt_addr)) imem_rdata <= 16'hFFFF;
    else imem_rdata <= 16'h1000 + {8'h00, imem_addr};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic at_neg(input int c);
    goto(c);
    @(negedge CLK);
  endtask

  task automatic exp_range(input logic [7:0] start, input int n);
    logic [7:0] p;
    p = start;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({p, 16'h1000 + {8'h00, p}});
      p = p + 8'd1;
    end
  endtask

  // Monitor / scoreboard: compares every accepted head entry, plus per-cycle invariants
  always @(negedge CLK) begin
    logic [23:0] e;
    if (!RESET) begin
      checks++;
      if ((dbg_count > 2'd2) ||
          (dbg_inflight && !flush && (dbg_count == 2'd2) && !(dec_valid && dec_ready))) begin
        errors++;
        $display("FAIL queue_overflow: count=%0d inflight=%0d expected count<=2 and no push into full queue",
                 dbg_count, dbg_inflight);
      end
      check("dec_valid_eq", {31'd0, dec_valid}, {31'd0, (dbg_count != 2'd0) && !flush});
      if (dec_valid && dec_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pop: got pc=%0h instr=%0h expected no delivery", dec_pc, dec_instr);
        end else begin
          e = exp_q.pop_front();
          check("dec_entry", {8'h00, dec_pc, dec_instr}, {8'h00, e});
        end
      end
    end
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout expected end of script");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    RESET       = 1'b1;
    flush       = 1'b0;
    dec_ready   = 1'b0;
    redirect_pc = 8'h00;
    halt_en     = 1'b0;
    halt_addr   = 8'h05;

    // Reset values
    @(negedge CLK);
    check("rst_state",    {30'd0, dbg_state}, 32'd0);
    check("rst_count",    {30'd0, dbg_count}, 32'd0);
    check("rst_inflight", {31'd0, dbg_inflight}, 32'd0);
    check("rst_valid",    {31'd0, dec_valid}, 32'd0);
    check("rst_pc_en",    {31'd0, pc_en}, 32'd0);
    check("rst_halted",   {31'd0, halted}, 32'd0);

    // Streaming from address 0
    goto(3);
    RESET = 1'b0;
    dec_ready = 1'b1;
    R = cyc;
    exp_range(8'h00, 8);
    @(negedge CLK);
    check("idle_no_issue", {31'd0, pc_en}, 32'd0);
    at_neg(R + 1);
    check("first_issue", {31'd0, pc_en}, 32'd1);
    check("first_issue_addr", {24'd0, imem_addr}, 32'h00);
    at_neg(R + 2);
    check("valid_not_yet", {31'd0, dec_valid}, 32'd0);
    at_neg(R + 3);
    check("valid_latency", {31'd0, dec_valid}, 32'd1);

    // Flush with one queued and one in flight, redirect to 20, then stall
    goto(R + 11);
    flush = 1'b1;
    redirect_pc = 8'h20;
    dec_ready = 1'b0;
    F = cyc;
    @(negedge CLK);
    check("flush_valid", {31'd0, dec_valid}, 32'd0);
    check("flush_no_issue", {31'd0, pc_en}, 32'd0);
    goto(F + 1);
    flush = 1'b0;
    exp_range(8'h20, 6);
    at_neg(F + 4);
    check("stall_count", {30'd0, dbg_count}, 32'd2);
    check("stall_inflight", {31'd0, dbg_inflight}, 32'd0);
    check("stall_pc_en", {31'd0, pc_en}, 32'd0);
    at_neg(F + 6);
    check("stall_count2", {30'd0, dbg_count}, 32'd2);
    check("stall_pc_en2", {31'd0, pc_en}, 32'd0);
    goto(F + 7);
    dec_ready = 1'b1;

    // Stall again until full, then flush redirect to 40
    goto(F + 13);
    dec_ready = 1'b0;
    G = cyc;
    goto(G + 3);
    check("full_before_flush", {30'd0, dbg_count}, 32'd2);
    flush = 1'b1;
    redirect_pc = 8'h40;
    dec_ready = 1'b1;
    H = cyc;
    exp_range(8'h40, 4);
    goto(H + 1);
    flush = 1'b0;
    at_neg(H + 3);
    check("redirect_head_pc", {24'd0, dec_pc}, 32'h40);
    check("redirect_head_instr", {16'd0, dec_instr}, 32'h1040);

    // Halt opcode at address 05
    goto(H + 7);
    flush = 1'b1;
    redirect_pc = 8'h02;
    halt_en = 1'b1;
    exp_range(8'h02, 3);
    exp_q.push_back({8'h05, 16'hFFFF});
    goto(H + 8);
    flush = 1'b0;
    at_neg(H + 15);
    check("halted", {31'd0, halted}, 32'd1);
    check("halted_state", {30'd0, dbg_state}, 32'd2);
    check("halted_pc_en", {31'd0, pc_en}, 32'd0);
    check("halted_drained", {31'd0, dec_valid}, 32'd0);
    at_neg(H + 16);
    check("halted_pc_en2", {31'd0, pc_en}, 32'd0);
    check("halted_pc_hold", {24'd0, pc_addr}, 32'h06);
    goto(H + 17);
    flush = 1'b1;
    redirect_pc = 8'h10;
    exp_range(8'h10, 3);
    goto(H + 18);
    flush = 1'b0;
    @(negedge CLK);
    check("unhalt", {31'd0, halted}, 32'd0);
    check("restart_issue", {31'd0, pc_en}, 32'd1);
    check("restart_addr", {24'd0, imem_addr}, 32'h10);

    // Reset pulse with a queued entry and one in flight
    goto(H + 23);
    dec_ready = 1'b0;
    @(negedge CLK);
    check("pre_reset_valid", {31'd0, dec_valid}, 32'd1);
    check("pre_reset_inflight", {31'd0, dbg_inflight}, 32'd1);
    RESET = 1'b1;
    halt_en = 1'b0;
    #1;
    check("mid_reset_valid", {31'd0, dec_valid}, 32'd0);
    check("mid_reset_count", {30'd0, dbg_count}, 32'd0);
    check("mid_reset_inflight", {31'd0, dbg_inflight}, 32'd0);
    check("mid_reset_state", {30'd0, dbg_state}, 32'd0);
    goto(H + 26);
    RESET = 1'b0;
    dec_ready = 1'b1;
    R2 = cyc;
    exp_range(8'h00, 4);
    at_neg(R2 + 3);
    check("reset_addr_pc", {24'd0, dec_pc}, 32'h00);

    // Wrap-around FE, FF, 00, 01
    goto(R2 + 7);
    flush = 1'b1;
    redirect_pc = 8'hFE;
    W = cyc;
    exp_q.push_back({8'hFE, 16'h10FE});
    exp_q.push_back({8'hFF, 16'h10FF});
    exp_q.push_back({8'h00, 16'h1000});
    exp_q.push_back({8'h01, 16'h1001});
    goto(W + 1);
    flush = 1'b0;
    goto(W + 7);
    flush = 1'b1;
    redirect_pc = 8'h80;
    dec_ready = 1'b0;
    goto(W + 8);
    flush = 1'b0;
    goto(W + 12);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
